cache_arbiter: RTL

- Shares the single physical-memory port between the instruction cache and the data cache of the pipelined RISC-V core.
- Sits between the two cache line-fill/write-back interfaces and main memory.
- Grants one requester per transaction, registers its address and write data, and returns the memory response and read data to that requester only.
- Fixed-priority arbitration by default, with data cache winning ties so the MEM stage (which stalls the whole pipe) is never starved by fetch.

---
 rtl/cache_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/cache_arbiter.sv
// Arbitrates the single physical-memory port between the icache and the dcache.
// Optional macro CACHE_ARBITER_ROUND_ROBIN_EN replaces fixed d-over-i priority with tie-alternation.
module cache_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  i_pmem_read,
    input  logic [ADDR_WIDTH-1:0] i_pmem_address,
    output logic [LINE_WIDTH-1:0] i_pmem_rdata,
    output logic                  i_pmem_resp,

    input  logic                  d_pmem_read,
    input  logic                  d_pmem_write,
    input  logic [ADDR_WIDTH-1:0] d_pmem_address,
    input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
    output logic [LINE_WIDTH-1:0] d_pmem_rdata,
    output logic                  d_pmem_resp,

    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SERVE_I = 2'd1;
    localparam logic [1:0] SERVE_D = 2'd2;

    logic [1:0]            state_q, state_d;
    logic                  op_write_q, op_write_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LINE_WIDTH-1:0] wdata_q, wdata_d;

    logic d_req;
    logic grant_d;

    assign d_req = d_pmem_read | d_pmem_write;

`ifdef CACHE_ARBITER_ROUND_ROBIN_EN
    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    logic last_grant_q, last_grant_d;

    // On a tie, the side that did not win last time goes first.
    assign grant_d = d_req & (~i_pmem_read | (last_grant_q == GRANT_I));

    always_comb begin
        last_grant_d = last_grant_q;
        if (state_q == IDLE) begin
            if (grant_d)
                last_grant_d = GRANT_D;
            else if (i_pmem_read)
                last_grant_d = GRANT_I;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_grant_q <= GRANT_I;
        else
            last_grant_q <= last_grant_d;
    end
`else
    assign grant_d = d_req;
`endif

    always_comb begin
        state_d    = state_q;
        op_write_d = op_write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d    = SERVE_D;
                    op_write_d = d_pmem_write;
                    addr_d     = d_pmem_address;
                    wdata_d    = d_pmem_wdata;
                end else if (i_pmem_read) begin
                    state_d    = SERVE_I;
                    op_write_d = 1'b0;
                    addr_d     = i_pmem_address;
                end
            end
            SERVE_I, SERVE_D: begin
                // Returning to IDLE forces the one-cycle gap between transactions.
                if (pmem_resp)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            op_write_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            op_write_q <= op_write_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign pmem_read    = (state_q == SERVE_I) | ((state_q == SERVE_D) & ~op_write_q);
    assign pmem_write   = (state_q == SERVE_D) & op_write_q;
    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;

    assign i_pmem_resp  = (state_q == SERVE_I) & pmem_resp;
    assign d_pmem_resp  = (state_q == SERVE_D) & pmem_resp;
    assign i_pmem_rdata = i_pmem_resp ? pmem_rdata : '0;
    assign d_pmem_rdata = d_pmem_resp ? pmem_rdata : '0;

endmodule
